// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: shared state type and round-robin helper for the crossbar allocator
package cross_bar_pkg;

    typedef enum logic {ALLOC_IDLE, ALLOC_BUSY} alloc_state_t;

    function automatic int rr_next(input int ptr, input int s);
        return (ptr >= s - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cross_bar_rr_pick.sv
// cross_bar_rr_pick: round-robin pick of the first request after ptr, wrapping mod N
module cross_bar_rr_pick
    import cross_bar_pkg::*;
#(
    parameter int N         = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 any,
    output logic [IDX_WIDTH-1:0] idx
);

    logic [2*N-1:0] dbl;
    int             start;
    int             pos;

    // Lower copy keeps only bits at or after start; upper copy supplies the wrap-around.
    always_comb begin
        start = rr_next(int'(ptr), N);
        for (int k = 0; k < N; k++) begin
            dbl[k]     = req[k] & (k >= start);
            dbl[N + k] = req[k];
        end
        pos = 0;
        for (int k = 2 * N - 1; k >= 0; k--) begin
            if (dbl[k]) pos = k;
        end
        any = |req;
        idx = IDX_WIDTH'((pos >= N) ? pos - N : pos);
    end

endmodule

// File: rtl/cross_bar_switch_allocator.sv
// cross_bar_switch_allocator: packet-atomic per-output round-robin allocator for an SxM crossbar
module cross_bar_switch_allocator
    import cross_bar_pkg::*;
#(
    parameter int S_CHANNELS = 4,
    parameter int M_CHANNELS = 4,
    parameter int SSEL_WIDTH = (S_CHANNELS > 1) ? $clog2(S_CHANNELS) : 1,
    parameter int MSEL_WIDTH = (M_CHANNELS > 1) ? $clog2(M_CHANNELS) : 1
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [S_CHANNELS-1:0]            s_req_valid,
    input  logic [S_CHANNELS*MSEL_WIDTH-1:0] s_req_dest,
    input  logic [S_CHANNELS-1:0]            s_pkt_done,
    input  logic [M_CHANNELS-1:0]            m_enable,
    output logic [M_CHANNELS*SSEL_WIDTH-1:0] m_sel,
    output logic [M_CHANNELS-1:0]            m_sel_valid,
    output logic [S_CHANNELS-1:0]            s_grant,
    output logic [S_CHANNELS*MSEL_WIDTH-1:0] s_grant_port,
    output logic                             err_bad_dest
);

    alloc_state_t                          state_q [M_CHANNELS];
    alloc_state_t                          state_d [M_CHANNELS];
    logic [SSEL_WIDTH-1:0]                 sel_q   [M_CHANNELS];
    logic [SSEL_WIDTH-1:0]                 sel_d   [M_CHANNELS];
    logic [SSEL_WIDTH-1:0]                 ptr_q   [M_CHANNELS];
    logic [SSEL_WIDTH-1:0]                 ptr_d   [M_CHANNELS];
    logic [SSEL_WIDTH-1:0]                 pick_idx[M_CHANNELS];
    logic [M_CHANNELS-1:0]                 pick_any;
    logic [M_CHANNELS-1:0][S_CHANNELS-1:0] req_m;
    logic                                  err_q;
    logic                                  err_d;

    always_comb begin
        s_grant      = '0;
        s_grant_port = '0;
        for (int j = 0; j < M_CHANNELS; j++) begin
            for (int i = 0; i < S_CHANNELS; i++) begin
                if (state_q[j] == ALLOC_BUSY && sel_q[j] == SSEL_WIDTH'(i)) begin
                    s_grant[i]                               = 1'b1;
                    s_grant_port[i*MSEL_WIDTH +: MSEL_WIDTH] = MSEL_WIDTH'(j);
                end
            end
        end
    end

    // Already-connected inputs are masked so a held head cannot win a second output.
    always_comb begin
        err_d = 1'b0;
        for (int j = 0; j < M_CHANNELS; j++) begin
            for (int i = 0; i < S_CHANNELS; i++) begin
                req_m[j][i] = s_req_valid[i] & ~s_grant[i] & m_enable[j] &
                              (s_req_dest[i*MSEL_WIDTH +: MSEL_WIDTH] == MSEL_WIDTH'(j));
            end
        end
        for (int i = 0; i < S_CHANNELS; i++) begin
            err_d = err_d | (s_req_valid[i] & ~s_grant[i] &
                             (int'(s_req_dest[i*MSEL_WIDTH +: MSEL_WIDTH]) >= M_CHANNELS));
        end
    end

    always_comb begin
        for (int j = 0; j < M_CHANNELS; j++) begin
            state_d[j] = state_q[j];
            sel_d[j]   = sel_q[j];
            ptr_d[j]   = ptr_q[j];
            if (state_q[j] == ALLOC_IDLE && pick_any[j]) begin
                state_d[j] = ALLOC_BUSY;
                sel_d[j]   = pick_idx[j];
                ptr_d[j]   = pick_idx[j];
            end else if (state_q[j] == ALLOC_BUSY && s_pkt_done[sel_q[j]]) begin
                state_d[j] = ALLOC_IDLE;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int j = 0; j < M_CHANNELS; j++) begin
                state_q[j] <= ALLOC_IDLE;
                sel_q[j]   <= '0;
                ptr_q[j]   <= SSEL_WIDTH'(S_CHANNELS - 1);
            end
            err_q <= 1'b0;
        end else begin
            for (int j = 0; j < M_CHANNELS; j++) begin
                state_q[j] <= state_d[j];
                sel_q[j]   <= sel_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
            err_q <= err_d;
        end
    end

    for (genvar j = 0; j < M_CHANNELS; j++) begin : g_out
        cross_bar_rr_pick #(
            .N         (S_CHANNELS),
            .IDX_WIDTH (SSEL_WIDTH)
        ) u_pick (
            .req (req_m[j]),
            .ptr (ptr_q[j]),
            .any (pick_any[j]),
            .idx (pick_idx[j])
        );
        assign m_sel[j*SSEL_WIDTH +: SSEL_WIDTH] = sel_q[j];
        assign m_sel_valid[j]                    = (state_q[j] == ALLOC_BUSY);
    end

    assign err_bad_dest = err_q;

endmodule

// File: tb/tb_cross_bar_switch_allocator.sv
// tb_cross_bar_switch_allocator: vector table, directed sequences and randomized model comparison
module tb_cross_bar_switch_allocator;

    logic       aclk = 1'b0;
    logic       areset;
    logic [3:0] s_req_valid;
    logic [7:0] s_req_dest;
    logic [3:0] s_pkt_done;
    logic [3:0] m_enable;

    logic [7:0] m_sel4;
    logic [3:0] msv4;
    logic [3:0] grant4;
    logic [7:0] port4;
    logic       err4;
    logic [5:0] m_sel3;
    logic [2:0] msv3;
    logic [3:0] grant3;
    logic [7:0] port3;
    logic       err3;

    cross_bar_switch_allocator #(.S_CHANNELS(4), .M_CHANNELS(4)) dut4 (
        .aclk         (aclk),
        .areset       (areset),
        .s_req_valid  (s_req_valid),
        .s_req_dest   (s_req_dest),
        .s_pkt_done   (s_pkt_done),
        .m_enable     (m_enable),
        .m_sel        (m_sel4),
        .m_sel_valid  (msv4),
        .s_grant      (grant4),
        .s_grant_port (port4),
        .err_bad_dest (err4)
    );

    cross_bar_switch_allocator #(.S_CHANNELS(4), .M_CHANNELS(3)) dut3 (
        .aclk         (aclk),
        .areset       (areset),
        .s_req_valid  (s_req_valid),
        .s_req_dest   (s_req_dest),
        .s_pkt_done   (s_pkt_done),
        .m_enable     (m_enable[2:0]),
        .m_sel        (m_sel3),
        .m_sel_valid  (msv3),
        .s_grant      (grant3),
        .s_grant_port (port3),
        .err_bad_dest (err3)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int passed = 0;

    logic [63:0] act4, act3;
    assign act4 = 64'({err4, port4, grant4, m_sel4, msv4});
    assign act3 = 64'({err3, port3, grant3, 2'b00, m_sel3, 1'b0, msv3});

    // Reference model: per-output connection owner and last winner, for M=4 (0) and M=3 (1)
    int mc[2] = '{4, 3};
    int busy[2][4];
    int owner[2][4];
    int last[2][4];
    int err_m[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int dest_of(int i);
        logic [7:0] d;
        d = s_req_dest;
        return int'(d[2*i +: 2]);
    endfunction

    function automatic void model_step();
        int nb[4], no[4], nl[4];
        int granted[4];
        int c;
        for (int n = 0; n < 2; n++) begin
            if (areset) begin
                for (int j = 0; j < 4; j++) begin
                    busy[n][j] = 0; owner[n][j] = 0; last[n][j] = 3;
                end
                err_m[n] = 0;
                continue;
            end
            for (int i = 0; i < 4; i++) granted[i] = 0;
            for (int j = 0; j < mc[n]; j++) if (busy[n][j] != 0) granted[owner[n][j]] = 1;
            for (int j = 0; j < 4; j++) begin
                nb[j] = busy[n][j]; no[j] = owner[n][j]; nl[j] = last[n][j];
                if (j >= mc[n]) continue;
                if (busy[n][j] != 0) begin
                    if (s_pkt_done[owner[n][j]]) nb[j] = 0;
                end else if (m_enable[j]) begin
                    for (int k = 1; k <= 4; k++) begin
                        c = (last[n][j] + k) % 4;
                        if (s_req_valid[c] && dest_of(c) == j && granted[c] == 0) begin
                            nb[j] = 1; no[j] = c; nl[j] = c;
                            break;
                        end
                    end
                end
            end
            err_m[n] = 0;
            for (int i = 0; i < 4; i++)
                if (s_req_valid[i] && granted[i] == 0 && dest_of(i) >= mc[n]) err_m[n] = 1;
            for (int j = 0; j < 4; j++) begin
                busy[n][j] = nb[j]; owner[n][j] = no[j]; last[n][j] = nl[j];
            end
        end
    endfunction

    function automatic logic [63:0] expv(int n);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < mc[n]; j++) begin
            r[j]             = (busy[n][j] != 0);
            r[4 + 2*j +: 2]  = 2'(owner[n][j]);
            if (busy[n][j] != 0) begin
                r[12 + owner[n][j]]          = 1'b1;
                r[16 + 2*owner[n][j] +: 2]   = 2'(j);
            end
        end
        r[24] = (err_m[n] != 0);
        return r;
    endfunction

    task automatic step();
        model_step();
        @(posedge aclk);
        #1;
        chk("model_m4", act4, expv(0));
        chk("model_m3", act3, expv(1));
    endtask

    task automatic reset_all();
        areset = 1'b1; s_req_valid = '0; s_req_dest = '0; s_pkt_done = '0; m_enable = 4'hF;
        step();
        areset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] v;
        logic [7:0] d;
        logic [3:0] en;
        logic [3:0] msv;
        logic [7:0] sel;
        logic [3:0] g;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[7];
    int   exp_order[5] = '{0, 1, 3, 0, 1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'h0, 8'h00, 4'hF, 4'h0, 8'h00, 4'h0, 8'h00};
        vecs[1] = '{4'h4, 8'h10, 4'hF, 4'h2, 8'h08, 4'h4, 8'h10};
        vecs[2] = '{4'h3, 8'h0E, 4'hF, 4'hC, 8'h40, 4'h3, 8'h0E};
        vecs[3] = '{4'h9, 8'h00, 4'hF, 4'h1, 8'h00, 4'h1, 8'h00};
        vecs[4] = '{4'hF, 8'hFF, 4'hF, 4'h8, 8'h00, 4'h1, 8'h03};
        vecs[5] = '{4'h6, 8'h00, 4'hF, 4'h1, 8'h01, 4'h2, 8'h00};
        vecs[6] = '{4'h2, 8'h08, 4'hB, 4'h0, 8'h00, 4'h0, 8'h00};

        reset_all();
        chk("reset_state", {msv4, grant4, 3'b000, err4}, '0);

        foreach (vecs[v]) begin
            reset_all();
            s_req_valid = vecs[v].v; s_req_dest = vecs[v].d; m_enable = vecs[v].en;
            step();
            chk($sformatf("vec%0d_msv", v), msv4, vecs[v].msv);
            chk($sformatf("vec%0d_sel", v), m_sel4 & {{2{msv4[3]}}, {2{msv4[2]}}, {2{msv4[1]}}, {2{msv4[0]}}}, vecs[v].sel);
            chk($sformatf("vec%0d_grant", v), grant4, vecs[v].g);
            chk($sformatf("vec%0d_port", v), port4, vecs[v].p);
        end

        begin : single_hold
            int held;
            reset_all();
            s_req_valid = 4'b0100; s_req_dest = 8'h10;
            step();
            chk("hold_grant", {msv4[1], m_sel4[3:2], grant4[2], port4[5:4]}, {1'b1, 2'd2, 1'b1, 2'd1});
            s_req_valid = '0;
            held = 0;
            repeat (10) begin
                step();
                held += int'(msv4[1]);
            end
            chk("hold_10", held, 10);
            s_pkt_done = 4'b0100;
            step();
            s_pkt_done = '0;
            chk("release", {msv4[1], m_sel4[3:2]}, {1'b0, 2'd2});
        end

        begin : rr_sequence
            int   order[$];
            int   gaps[$];
            int   cnt, idle;
            logic prev;
            reset_all();
            s_req_valid = 4'b1011; s_req_dest = 8'h00;
            cnt = 0; idle = 0; prev = 1'b0;
            for (int c = 0; c < 80 && order.size() < 5; c++) begin
                s_pkt_done = (busy[0][0] != 0 && cnt == 4) ? 4'(1 << owner[0][0]) : 4'b0;
                step();
                if (msv4[0] && !prev) begin
                    order.push_back(int'(m_sel4[1:0]));
                    if (order.size() > 1) gaps.push_back(idle);
                    cnt = 1; idle = 0;
                end else if (msv4[0]) cnt++;
                else idle++;
                prev = msv4[0];
            end
            s_pkt_done = '0; s_req_valid = '0;
            chk("rr_count", order.size(), 5);
            foreach (order[k]) if (k < 5) chk($sformatf("rr_order%0d", k), order[k], exp_order[k]);
            foreach (gaps[k]) chk($sformatf("rr_gap%0d", k), gaps[k], 1);
        end

        reset_all();
        m_enable = 4'b1011; s_req_valid = 4'b0010; s_req_dest = 8'h08;
        repeat (3) step();
        chk("enable_gated", msv4[2], 1'b0);
        m_enable = 4'hF;
        step();
        chk("enable_grant", {msv4[2], m_sel4[5:4]}, {1'b1, 2'd1});
        m_enable = 4'b1011;
        repeat (3) step();
        chk("busy_ignores_enable", msv4[2], 1'b1);
        s_pkt_done = 4'b0010;
        step();
        s_pkt_done = '0;
        chk("enable_release", msv4[2], 1'b0);
        repeat (3) step();
        chk("no_regrant", msv4[2], 1'b0);

        reset_all();
        s_req_valid = 4'b0011; s_req_dest = 8'h04;
        step();
        chk("pre_reset_busy", msv4[1:0], 2'b11);
        s_req_valid = '0; areset = 1'b1;
        step();
        areset = 1'b0;
        chk("reset_drop", {msv4, grant4}, 8'h00);
        s_req_valid = 4'b1001; s_req_dest = 8'h00;
        step();
        chk("reset_ptr", {msv4[0], m_sel4[1:0]}, {1'b1, 2'd0});

        reset_all();
        s_req_valid = 4'b0100; s_req_dest = 8'h30;
        step();
        chk("bad_dest_1", {err3, msv3}, {1'b1, 3'b000});
        step();
        chk("bad_dest_2", {err3, grant3}, {1'b1, 4'b0000});
        s_req_valid = '0;
        step();
        chk("bad_dest_end", err3, 1'b0);

        reset_all();
        repeat (500) begin
            areset      = ($urandom_range(63) == 0);
            s_req_valid = 4'($urandom);
            s_req_dest  = 8'($urandom);
            s_pkt_done  = 4'($urandom) & 4'($urandom);
            m_enable    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
